main_memory_responder: RTL and testbench

MAIN_MEMORY_RESPONDER -- requirements
Module: main_memory_responder

---
 rtl/main_memory_responder.sv | 124 ++++++++++++
 tb/tb_main_memory_responder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/main_memory_responder.sv
// Block-granular main-memory model for a cache: accepts one fill or write-back at a time,
// responds after a fixed latency with a burst of read beats or a single write acknowledge.
module main_memory_responder #(
  parameter int DATA_SIZE  = 32,
  parameter int ADDR_SIZE  = 32,
  parameter int BLOCK_SIZE = 16,
  parameter int MEM_WORDS  = 2**20,
  parameter int LATENCY    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_SIZE-1:0]    req_addr,
  input  logic [BLOCK_SIZE*8-1:0] req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_SIZE-1:0]    resp_data,
  output logic                    resp_last,
  output logic                    resp_write,
  output logic [15:0]             rd_count,
  output logic [15:0]             wr_count
);

  localparam int BEATS      = BLOCK_SIZE * 8 / DATA_SIZE;
  localparam int WORD_SHIFT = $clog2(DATA_SIZE / 8);
  localparam int IDX_W      = $clog2(MEM_WORDS);
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LAT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);
  localparam logic [IDX_W-1:0]  ALIGN_MASK = ~IDX_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, WAIT, XFER, ACK} state_t;

  state_t               state_reg, state_next;
  logic [IDX_W-1:0]     base_reg;
  logic                 write_reg;
  logic [LAT_W-1:0]     lat_reg;
  logic [BEAT_W-1:0]    beat_reg, beat_next;
  logic [15:0]          rd_count_reg, wr_count_reg;
  logic [DATA_SIZE-1:0] rd_data_reg;
  logic [IDX_W-1:0]     req_base, rd_index;
  logic                 accept, final_beat;

  logic [DATA_SIZE-1:0] mem [MEM_WORDS];

  // Upper address bits beyond the memory depth simply alias.
  assign req_base   = IDX_W'(req_addr >> WORD_SHIFT) & ALIGN_MASK;
  assign accept     = req_valid && (state_reg == IDLE) && !rst;
  assign final_beat = resp_ready && ((state_reg == ACK) ||
                      ((state_reg == XFER) && (beat_reg == LAST_BEAT)));

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (req_valid) state_next = WAIT;
      WAIT: if (lat_reg == '0) state_next = write_reg ? ACK : XFER;
      XFER: if (resp_ready && (beat_reg == LAST_BEAT)) state_next = IDLE;
      ACK:  if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_reg == IDLE);
    resp_valid = (state_reg == XFER) || (state_reg == ACK);
    resp_write = (state_reg == ACK);
    resp_last  = (state_reg == ACK) || ((state_reg == XFER) && (beat_reg == LAST_BEAT));
    resp_data  = (state_reg == XFER) ? rd_data_reg : '0;
  end

  // The read address looks one beat ahead so the registered read lands as the beat is shown.
  always_comb begin
    beat_next = '0;
    if (state_reg == XFER) begin
      beat_next = beat_reg;
      if (resp_ready) beat_next = (beat_reg == LAST_BEAT) ? '0 : beat_reg + BEAT_W'(1);
    end
  end

  assign rd_index = base_reg + IDX_W'(beat_next);

  always_ff @(posedge clk) begin
    if (rst) begin
      base_reg     <= '0;
      write_reg    <= 1'b0;
      lat_reg      <= '0;
      beat_reg     <= '0;
      rd_count_reg <= '0;
      wr_count_reg <= '0;
    end else begin
      beat_reg <= beat_next;
      if (accept) begin
        base_reg  <= req_base;
        write_reg <= req_write;
        lat_reg   <= LAT_W'(LATENCY - 1);
      end else if ((state_reg == WAIT) && (lat_reg != '0)) begin
        lat_reg <= lat_reg - LAT_W'(1);
      end
      if (final_beat && (state_reg == XFER)) rd_count_reg <= rd_count_reg + 16'd1;
      if (final_beat && (state_reg == ACK))  wr_count_reg <= wr_count_reg + 16'd1;
    end
  end

  // Memory is never reset; a write-back commits the whole block at acceptance.
  always_ff @(posedge clk) begin
    if (accept && req_write) begin
      for (int i = 0; i < BEATS; i++) begin
        mem[req_base + IDX_W'(i)] <= req_wdata[i*DATA_SIZE +: DATA_SIZE];
      end
    end
    rd_data_reg <= mem[rd_index];
  end

  assign rd_count = rd_count_reg;
  assign wr_count = wr_count_reg;

endmodule

// File: tb/tb_main_memory_responder.sv
// Bench for main_memory_responder: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a transaction-level model.
module tb_main_memory_responder;

  localparam int MW  = 4096;
  localparam int LAT = 4;

  logic         clk = 0;
  logic         rst = 1;
  logic         req_valid = 0;
  logic         req_ready;
  logic         req_write = 0;
  logic [31:0]  req_addr = '0;
  logic [127:0] req_wdata = '0;
  logic         resp_valid;
  logic         resp_ready = 1;
  logic [31:0]  resp_data;
  logic         resp_last;
  logic         resp_write;
  logic [15:0]  rd_count, wr_count;

  main_memory_responder #(
    .DATA_SIZE(32), .ADDR_SIZE(32), .BLOCK_SIZE(16), .MEM_WORDS(MW), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_last(resp_last), .resp_write(resp_write),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: memory image, pending beat list and completion counters.
  typedef struct {
    logic [31:0] d;
    bit          last;
    bit          wr;
    bit          known;
  } beat_t;
  typedef struct {
    int          c;
    logic [31:0] d;
    logic        l;
    logic        w;
  } obs_t;

  logic [31:0] m_mem   [MW];
  bit          m_known [MW];
  beat_t       m_q[$];
  obs_t        obs[$];
  bit          m_busy = 0;
  bit          m_init = 0;
  int          m_t0   = 0;
  int          m_rdc  = 0;
  int          m_wrc  = 0;
  bit          auto_rr = 0;

  function automatic int block_base(input logic [31:0] a);
    return ((a / 4) % MW) / 4 * 4;
  endfunction

  always @(negedge clk) begin
    automatic bit exp_rv = m_busy && (cyc >= m_t0 + LAT);
    automatic int b;
    automatic beat_t nb;
    if (m_init) begin
      chk("req_ready", 64'(req_ready), 64'(!m_busy));
      chk("resp_valid", 64'(resp_valid), 64'(exp_rv));
      if (exp_rv && m_q.size() > 0) begin
        if (m_q[0].known) chk("resp_data", 64'(resp_data), 64'(m_q[0].d));
        chk("resp_last", 64'(resp_last), 64'(m_q[0].last));
        chk("resp_write", 64'(resp_write), 64'(m_q[0].wr));
      end else if (!exp_rv) begin
        chk("idle_data", 64'(resp_data), 64'd0);
        chk("idle_last", 64'(resp_last), 64'd0);
        chk("idle_write", 64'(resp_write), 64'd0);
      end
      chk("rd_count", 64'(rd_count), 64'(m_rdc));
      chk("wr_count", 64'(wr_count), 64'(m_wrc));
    end
    if (resp_valid && resp_ready && !rst)
      obs.push_back('{c: cyc, d: resp_data, l: resp_last, w: resp_write});
    // predict the effect of the coming edge
    if (rst) begin
      m_busy = 0;
      m_q.delete();
      m_rdc  = 0;
      m_wrc  = 0;
      m_init = 1;
    end else if (m_busy) begin
      if (exp_rv && resp_ready) begin
        nb = m_q.pop_front();
        if (m_q.size() == 0) begin
          m_busy = 0;
          if (nb.wr) m_wrc = (m_wrc + 1) % 65536;
          else       m_rdc = (m_rdc + 1) % 65536;
        end
      end
    end else if (req_valid) begin
      m_busy = 1;
      m_t0   = cyc + 1;
      b      = block_base(req_addr);
      if (req_write) begin
        for (int i = 0; i < 4; i++) begin
          m_mem[b + i]   = req_wdata[i*32 +: 32];
          m_known[b + i] = 1;
        end
        m_q.push_back('{d: 32'd0, last: 1'b1, wr: 1'b1, known: 1'b1});
      end else begin
        for (int i = 0; i < 4; i++)
          m_q.push_back('{d: m_mem[b + i], last: (i == 3), wr: 1'b0, known: m_known[b + i]});
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (auto_rr) resp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic issue(input bit w, input logic [31:0] a, input logic [127:0] d, output int acc);
    bit done = 0;
    acc = -1;
    @(posedge clk);
    #1;
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #1;
        acc = cyc;
        req_valid = 0;
        done = 1;
      end
    end
    if (!done) begin
      req_valid = 0;
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: got no acceptance, expected one within 300 cycles");
    end
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(posedge clk);
      #1;
      if (!m_busy) done = 1;
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL idle_timeout: got busy, expected idle within 400 cycles");
    end
  endtask

  task automatic check_read(input string tag, input int base_i, input int acc,
                            input logic [127:0] blk, input int gap);
    chk({tag, "_nbeats"}, 64'(obs.size() - base_i), 64'd4);
    if (obs.size() - base_i == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk({tag, "_data"}, 64'(obs[base_i+i].d), 64'(blk[i*32 +: 32]));
        chk({tag, "_last"}, 64'(obs[base_i+i].l), 64'(i == 3));
        chk({tag, "_cycle"}, 64'(obs[base_i+i].c), 64'(acc + LAT + i + ((i > 0) ? gap : 0)));
      end
    end
  endtask

  localparam logic [127:0] BLK40 = 128'h00000044_00000033_00000022_00000011;
  localparam logic [127:0] BLK80 = 128'hCAFE0003_BEEF0002_DEAD0001_F00D0000;

  initial begin
    int acc, acc2;
    logic [31:0] a;
    logic [127:0] d;
    bit w;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    chk("reset_resp_valid", 64'(resp_valid), 64'd0);
    chk("reset_counts", 64'({rd_count, wr_count}), 64'd0);

    // write-back of a block, then a fill with an unaligned address in the same block
    obs.delete();
    issue(1, 32'h40, BLK40, acc);
    wait_idle();
    chk("wr_nbeats", 64'(obs.size()), 64'd1);
    if (obs.size() == 1) begin
      chk("wr_ack_cycle", 64'(obs[0].c), 64'(acc + 4));
      chk("wr_ack_flags", 64'({obs[0].w, obs[0].l}), 64'b11);
      chk("wr_ack_data", 64'(obs[0].d), 64'd0);
    end
    chk("wr_count_1", 64'(wr_count), 64'd1);

    obs.delete();
    issue(0, 32'h4C, '0, acc);
    wait_idle();
    check_read("rd4c", 0, acc, BLK40, 0);
    chk("rd_count_1", 64'(rd_count), 64'd1);

    // upper address bits alias onto the same block
    obs.delete();
    issue(0, MW * 4 + 32'h40, '0, acc);
    wait_idle();
    check_read("alias", 0, acc, BLK40, 0);

    // stall on beat 1 for three cycles
    obs.delete();
    issue(0, 32'h40, '0, acc);
    repeat (5) @(posedge clk);
    #1 resp_ready = 0;
    repeat (3) @(posedge clk);
    #1 resp_ready = 1;
    wait_idle();
    check_read("stall", 0, acc, BLK40, 3);

    // a request arriving during the burst waits for the return to idle
    obs.delete();
    issue(0, 32'h40, '0, acc);
    repeat (4) @(posedge clk);
    issue(0, 32'h48, '0, acc2);
    chk("busy_accept_cycle", 64'(acc2), 64'(acc + 9));
    wait_idle();
    chk("busy_nbeats", 64'(obs.size()), 64'd8);

    // reset in the latency window aborts the ack but keeps the committed data
    obs.delete();
    issue(1, 32'h80, BLK80, acc);
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_nbeats", 64'(obs.size()), 64'd0);
    chk("abort_wr_count", 64'(wr_count), 64'd0);
    issue(0, 32'h80, '0, acc);
    wait_idle();
    check_read("after_abort", 0, acc, BLK80, 0);

    // randomized traffic with back-pressure and occasional resets
    auto_rr = 1;
    for (int n = 0; n < 250; n++) begin
      w = 1'($urandom_range(0, 1));
      a = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 31)) << 4) | 32'($urandom_range(0, 15));
      d = {$urandom, $urandom, $urandom, $urandom};
      issue(w, a, d, acc);
      if ($urandom_range(0, 14) == 0) begin
        repeat ($urandom_range(0, 6)) @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
      end
      wait_idle();
    end
    auto_rr = 0;
    resp_ready = 1;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
